// File: rtl/rcn_slave.sv
// RCN ring responder: consumes requests in its address window, runs them on a
// one-cycle-latency local register bus and reinserts the responses into the ring.
module rcn_slave #(
    parameter logic [23:0] ADDR_BASE  = 24'h000000,
    parameter logic [23:0] ADDR_MASK  = 24'hFF0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [68:0] rcn_in,
    output logic [68:0] rcn_out,
    output logic        cs,
    output logic        wr,
    output logic [23:0] addr,
    output logic [3:0]  mask,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic          match;
    logic          credit;
    logic          consume;
    logic          push;
    logic          pop;
    logic [68:0]   resp;
    logic [68:0]   out_d;

    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [68:0]   mem [FIFO_DEPTH];

    // Request fields carried alongside the access stage
    logic [5:0]    id_q;
    logic [1:0]    seq_q;

    // Capture stage: access issued last cycle, rdata valid now
    logic          pend_q;
    logic          pend_wr_q;
    logic [5:0]    pend_id_q;
    logic [3:0]    pend_mask_q;
    logic [21:0]   pend_addr_q;
    logic [1:0]    pend_seq_q;
    logic [31:0]   pend_wdata_q;

    assign match = rcn_in[68] && rcn_in[67] &&
                   (({rcn_in[55:34], 2'b00} & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

    // Occupancy plus both pipeline stages reserves a FIFO slot per accepted request
    assign credit  = (32'(count_q) + 32'(cs) + 32'(pend_q)) < FIFO_DEPTH;
    assign consume = match && credit;
    assign push    = pend_q;
    assign pop     = (count_q != '0) && !(rcn_in[68] && !consume);

    assign resp = {1'b1, 1'b0, pend_wr_q, pend_id_q, pend_mask_q, pend_addr_q, pend_seq_q,
                   pend_wr_q ? pend_wdata_q : rdata};

    always_comb begin
        out_d = '0;
        if (rcn_in[68] && !consume) begin
            out_d = rcn_in;
        end else if (count_q != '0) begin
            out_d = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= resp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcn_out      <= '0;
            cs           <= 1'b0;
            wr           <= 1'b0;
            addr         <= '0;
            mask         <= '0;
            wdata        <= '0;
            id_q         <= '0;
            seq_q        <= '0;
            pend_q       <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_id_q    <= '0;
            pend_mask_q  <= '0;
            pend_addr_q  <= '0;
            pend_seq_q   <= '0;
            pend_wdata_q <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            rcn_out <= out_d;

            cs <= consume;
            if (consume) begin
                wr    <= rcn_in[66];
                addr  <= {rcn_in[55:34], 2'b00};
                mask  <= rcn_in[59:56];
                wdata <= rcn_in[31:0];
                id_q  <= rcn_in[65:60];
                seq_q <= rcn_in[33:32];
            end

            pend_q <= cs;
            if (cs) begin
                pend_wr_q    <= wr;
                pend_id_q    <= id_q;
                pend_mask_q  <= mask;
                pend_addr_q  <= addr[23:2];
                pend_seq_q   <= seq_q;
                pend_wdata_q <= wdata;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_rcn_slave.sv
// Directed bench for rcn_slave: a FIFO_DEPTH=4 instance and a FIFO_DEPTH=2 instance
// share one ring input so the shallow one can show credit refusal.
module tb_rcn_slave;

    logic        clk;
    logic        rst;
    logic [68:0] rcn_in;
    logic [31:0] rdata;

    logic [68:0] rcn_out,  rcn_out2;
    logic        cs,       cs2;
    logic        wr,       wr2;
    logic [23:0] addr,     addr2;
    logic [3:0]  mask,     mask2;
    logic [31:0] wdata,    wdata2;

    int n_checks;
    int n_errors;

    rcn_slave #(
        .ADDR_BASE (24'h010000),
        .ADDR_MASK (24'hFF0000),
        .FIFO_DEPTH(4)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .rcn_in (rcn_in),
        .rcn_out(rcn_out),
        .cs     (cs),
        .wr     (wr),
        .addr   (addr),
        .mask   (mask),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    rcn_slave #(
        .ADDR_BASE (24'h010000),
        .ADDR_MASK (24'hFF0000),
        .FIFO_DEPTH(2)
    ) u_dut2 (
        .clk    (clk),
        .rst    (rst),
        .rcn_in (rcn_in),
        .rcn_out(rcn_out2),
        .cs     (cs2),
        .wr     (wr2),
        .addr   (addr2),
        .mask   (mask2),
        .wdata  (wdata2),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [68:0] pkt(input logic req, input logic w, input logic [5:0] id,
                                        input logic [3:0] m, input logic [23:0] ba,
                                        input logic [1:0] sq, input logic [31:0] d);
        return {1'b1, req, w, id, m, ba[23:2], sq, d};
    endfunction

    function automatic logic [31:0] rd_model(input logic [23:0] a);
        return (a == 24'h010008) ? 32'hDEADBEEF : {8'hA5, a};
    endfunction

    // Local register model: data for the access seen this cycle appears next cycle
    task automatic tick();
        logic [23:0] a;
        logic        c;
        a = addr;
        c = cs;
        @(posedge clk);
        #1;
        rdata = c ? rd_model(a) : 32'h0;
    endtask

    logic [68:0] req  [6];
    logic [68:0] rsp  [6];
    logic [68:0] fpkt [21];
    logic [23:0] a_i;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        rcn_in   = '0;
        rdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rcn_out", rcn_out, '0);
        check("rst_cs", cs, '0);
        check("rst_wr", wr, '0);
        check("rst_addr", addr, '0);
        check("rst_mask", mask, '0);
        check("rst_wdata", wdata, '0);
        rst = 1'b0;
        tick();

        // Read on an idle ring
        rcn_in = pkt(1, 0, 6'd5, 4'hF, 24'h010008, 2'd2, 32'h0);
        tick();
        rcn_in = '0;
        check("rd_cs", cs, 1);
        check("rd_wr", wr, 0);
        check("rd_addr", addr, 24'h010008);
        check("rd_mask", mask, 4'hF);
        check("rd_slot_c1", rcn_out, '0);
        tick();
        check("rd_cs_c2", cs, 0);
        tick();
        check("rd_out_c3", rcn_out, '0);
        tick();
        check("rd_resp", rcn_out, pkt(0, 0, 6'd5, 4'hF, 24'h010008, 2'd2, 32'hDEADBEEF));
        repeat (3) tick();

        // Write with partial mask
        rcn_in = pkt(1, 1, 6'd3, 4'b0011, 24'h010010, 2'd1, 32'h12345678);
        tick();
        rcn_in = '0;
        check("wr_cs", cs, 1);
        check("wr_wr", wr, 1);
        check("wr_mask", mask, 4'b0011);
        check("wr_wdata", wdata, 32'h12345678);
        check("wr_addr", addr, 24'h010010);
        tick();
        check("wr_cs_c2", cs, 0);
        tick();
        tick();
        check("wr_resp", rcn_out, pkt(0, 1, 6'd3, 4'b0011, 24'h010010, 2'd1, 32'h12345678));
        repeat (3) tick();

        // Pass-through: out-of-window request and a foreign response
        rcn_in = pkt(1, 0, 6'd7, 4'hF, 24'h020000, 2'd0, 32'h0);
        tick();
        check("pt_req", rcn_out, pkt(1, 0, 6'd7, 4'hF, 24'h020000, 2'd0, 32'h0));
        check("pt_cs1", cs, 0);
        rcn_in = pkt(0, 0, 6'd9, 4'hF, 24'h010004, 2'd3, 32'hCAFEF00D);
        tick();
        rcn_in = '0;
        check("pt_rsp", rcn_out, pkt(0, 0, 6'd9, 4'hF, 24'h010004, 2'd3, 32'hCAFEF00D));
        check("pt_cs2", cs, 0);
        tick();
        check("pt_cs3", cs, 0);
        repeat (3) tick();

        // Six back-to-back reads
        for (int i = 0; i < 6; i++) begin
            a_i    = 24'h010100 + 24'(4 * i);
            req[i] = pkt(1, 0, 6'(i + 1), 4'hF, a_i, 2'(i), 32'h0);
            rsp[i] = pkt(0, 0, 6'(i + 1), 4'hF, a_i, 2'(i), {8'hA5, a_i});
        end
        for (int c = 0; c < 10; c++) begin
            rcn_in = (c < 6) ? req[c] : '0;
            check($sformatf("b2b_cs_c%0d", c), cs, (c >= 1 && c <= 6));
            if (c >= 1 && c <= 6) begin
                check($sformatf("b2b_addr_c%0d", c), addr, 24'h010100 + 24'(4 * (c - 1)));
            end
            check($sformatf("b2b_out_c%0d", c), rcn_out, (c >= 4) ? rsp[c - 4] : '0);
            check($sformatf("cr_cs_c%0d", c), cs2, (c == 1 || c == 2));
            if (c >= 3 && c <= 6) begin
                check($sformatf("cr_out_c%0d", c), rcn_out2, req[c - 1]);
            end else if (c == 7 || c == 8) begin
                check($sformatf("cr_out_c%0d", c), rcn_out2, rsp[c - 7]);
            end else begin
                check($sformatf("cr_out_c%0d", c), rcn_out2, '0);
            end
            tick();
        end
        repeat (3) tick();

        // Starved ring: response withheld until the first empty slot
        rcn_in = pkt(1, 0, 6'd12, 4'hF, 24'h010040, 2'd1, 32'h0);
        tick();
        for (int k = 1; k <= 20; k++) begin
            fpkt[k] = pkt(0, 1, 6'd20, 4'(k), 24'h030000, 2'd0, 32'h50000000 + 32'(k));
            rcn_in  = fpkt[k];
            check($sformatf("stv_out_c%0d", k), rcn_out, (k == 1) ? '0 : fpkt[k - 1]);
            tick();
        end
        rcn_in = '0;
        check("stv_out_c21", rcn_out, fpkt[20]);
        tick();
        check("stv_resp", rcn_out, pkt(0, 0, 6'd12, 4'hF, 24'h010040, 2'd1, 32'hA5010040));
        check("stv_resp2", rcn_out2, pkt(0, 0, 6'd12, 4'hF, 24'h010040, 2'd1, 32'hA5010040));
        repeat (3) tick();

        // Reset in cycle 2 of a read
        rcn_in = pkt(1, 0, 6'd33, 4'hF, 24'h010080, 2'd0, 32'h0);
        tick();
        rcn_in = pkt(0, 0, 6'd40, 4'h1, 24'h040000, 2'd2, 32'h77777777);
        check("rs_cs_c1", cs, 1);
        tick();
        rcn_in = '0;
        check("rs_out_pre", rcn_out, pkt(0, 0, 6'd40, 4'h1, 24'h040000, 2'd2, 32'h77777777));
        rst = 1'b1;
        #1;
        check("rs_out_async", rcn_out, '0);
        check("rs_cs_async", cs, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("rs_out_post%0d", c), rcn_out, '0);
            check($sformatf("rs_out2_post%0d", c), rcn_out2, '0);
            check($sformatf("rs_cs_post%0d", c), cs, 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
